// File: rtl/fft_result_serializer.sv
// ============================================================================
//  Module      : fft_result_serializer
//  Description : Captures one complex FFT result frame and streams it out
//                byte by byte (re0, im0, re1, im1, ...) over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_result_serializer #(
    parameter int N_POINTS = 4,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_ena,
    input  logic                         i_res_valid,
    input  logic [N_POINTS*DATA_W-1:0]   i_res_re,
    input  logic [N_POINTS*DATA_W-1:0]   i_res_im,
    output logic                         o_res_ready,
    input  logic                         i_out_ready,
    output logic [DATA_W-1:0]            o_out_data,
    output logic                         o_out_valid,
    output logic                         o_frame_done,
    output logic                         o_overrun,
    input  logic                         i_clr_overrun
);

    localparam int                 c_NWORDS = 2 * N_POINTS;
    localparam int                 c_IDX_W  = $clog2(c_NWORDS);
    localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(c_NWORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0]   r_buf [c_NWORDS];
    logic                r_frame_done;
    logic                r_overrun;
    logic                w_accept;
    logic                w_last;
    logic                w_capture;
    logic                w_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (i_ena) begin
            r_state <= w_state_nxt;
        end
    end

    // The last accept re-opens the input in the same cycle so a queued
    // frame can follow back-to-back without an idle gap.
    always_comb begin
        w_state_nxt = r_state;
        o_res_ready = 1'b0;
        o_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        if (rst_n && i_ena) begin
            case (r_state)
                S_IDLE: begin
                    o_res_ready = 1'b1;
                    if (i_res_valid) begin
                        w_state_nxt = S_STREAM;
                    end
                end
                S_STREAM: begin
                    o_out_valid = 1'b1;
                    w_accept    = i_out_ready;
                    w_last      = i_out_ready && (r_idx == c_LAST);
                    o_res_ready = w_last;
                    if (w_last && !i_res_valid) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    assign w_capture = o_res_ready & i_res_valid;
    assign w_drop    = rst_n & i_res_valid & ~o_res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            for (int k = 0; k < c_NWORDS; k++) begin
                r_buf[k] <= '0;
            end
        end else if (i_ena) begin
            r_frame_done <= w_last;
            if (w_capture) begin
                r_idx <= '0;
                for (int k = 0; k < N_POINTS; k++) begin
                    r_buf[2*k]   <= i_res_re[k*DATA_W +: DATA_W];
                    r_buf[2*k+1] <= i_res_im[k*DATA_W +: DATA_W];
                end
            end else if (w_accept) begin
                r_idx <= w_last ? '0 : r_idx + c_IDX_W'(1);
            end
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_out_data   = rst_n ? r_buf[r_idx] : '0;
    assign o_frame_done = r_frame_done;
    assign o_overrun    = r_overrun;

endmodule

`default_nettype wire
